// File: rtl/aes_decr_if.sv
// Request/response bundle for the iterative AES-128 decryptor.
// The requester drives ciphertext and key; the decryptor returns plaintext and status.
interface aes_decr_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int BLOCK_W = 16 * DATA_WIDTH;

  logic               ip_valid;
  logic               ip_ready;
  logic [BLOCK_W-1:0] ip_data;
  logic [BLOCK_W-1:0] ip_key;
  logic               out_valid;
  logic [BLOCK_W-1:0] decr_data_out;
  logic               busy;

  modport master (
    output ip_valid, ip_data, ip_key,
    input  ip_ready, out_valid, decr_data_out, busy
  );

  modport slave (
    input  ip_valid, ip_data, ip_key,
    output ip_ready, out_valid, decr_data_out, busy
  );
endinterface

// File: rtl/aes_decr.sv
// Iterative AES-128 inverse cipher, one round per clock: IDLE, INIT, 9 x ROUND, FINAL, DONE.
// Round keys are expanded combinationally from the registered key and consumed rk[10] down to rk[0].
module aes_decr #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  aes_decr_if.slave  bus
);
  localparam int BLOCK_W = 16 * DATA_WIDTH;
  localparam int WORD_W  = 4 * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] byte_t;
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_t;

  localparam logic [0:255][DATA_WIDTH-1:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Forward S-box is only needed by the key schedule (SubWord).
  localparam logic [0:255][DATA_WIDTH-1:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][DATA_WIDTH-1:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t xtime(input byte_t b);
    return {b[DATA_WIDTH-2:0], 1'b0} ^ (b[DATA_WIDTH-1] ? byte_t'(8'h1b) : byte_t'(8'h00));
  endfunction

  // Multiply by a 4-bit constant as a sum of b, 2b, 4b, 8b.
  function automatic byte_t gf_mul(input byte_t b, input logic [3:0] k);
    byte_t x2, x4, x8, p;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    p  = '0;
    if (k[0]) p = p ^ b;
    if (k[1]) p = p ^ x2;
    if (k[2]) p = p ^ x4;
    if (k[3]) p = p ^ x8;
    return p;
  endfunction

  function automatic logic [BLOCK_W-1:0] next_rk(input logic [BLOCK_W-1:0] k, input byte_t rc);
    logic [WORD_W-1:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {SBOX[w3[23:16]] ^ rc, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_t               fsm_reg, fsm_next;
  logic [3:0]         cnt_reg;
  logic [BLOCK_W-1:0] data_reg, key_reg, blk_reg, result_reg;
  logic [BLOCK_W-1:0] rk [0:10];
  logic [BLOCK_W-1:0] rk_sel;
  logic [BLOCK_W-1:0] sb_vec, ark_vec, round_out;

  always_comb begin
    rk[0] = key_reg;
    for (int i = 1; i <= 10; i++) begin
      rk[i] = next_rk(rk[i-1], RCON[i-1]);
    end
  end

  // In FINAL the counter has reached 0, so this also selects rk[0] there.
  always_comb begin
    rk_sel = (fsm_reg == INIT) ? rk[10] : rk[cnt_reg];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_inv_row_sub
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
      assign sb_vec[BLOCK_W-1-DATA_WIDTH*gi -: DATA_WIDTH] =
        INV_SBOX[blk_reg[BLOCK_W-1-DATA_WIDTH*SRC -: DATA_WIDTH]];
    end
  endgenerate

  assign ark_vec = sb_vec ^ rk_sel;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_inv_mix
      byte_t a0, a1, a2, a3;
      assign a0 = ark_vec[BLOCK_W-1-DATA_WIDTH*(4*gi+0) -: DATA_WIDTH];
      assign a1 = ark_vec[BLOCK_W-1-DATA_WIDTH*(4*gi+1) -: DATA_WIDTH];
      assign a2 = ark_vec[BLOCK_W-1-DATA_WIDTH*(4*gi+2) -: DATA_WIDTH];
      assign a3 = ark_vec[BLOCK_W-1-DATA_WIDTH*(4*gi+3) -: DATA_WIDTH];
      assign round_out[BLOCK_W-1-DATA_WIDTH*(4*gi+0) -: DATA_WIDTH] =
        gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      assign round_out[BLOCK_W-1-DATA_WIDTH*(4*gi+1) -: DATA_WIDTH] =
        gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      assign round_out[BLOCK_W-1-DATA_WIDTH*(4*gi+2) -: DATA_WIDTH] =
        gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      assign round_out[BLOCK_W-1-DATA_WIDTH*(4*gi+3) -: DATA_WIDTH] =
        gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    unique case (fsm_reg)
      IDLE:    if (bus.ip_valid) fsm_next = INIT;
      INIT:    fsm_next = ROUND;
      ROUND:   if (cnt_reg == 4'd1) fsm_next = FINAL;
      FINAL:   fsm_next = DONE;
      DONE:    fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ip_ready      = (fsm_reg == IDLE);
    bus.busy          = (fsm_reg != IDLE);
    bus.out_valid     = (fsm_reg == DONE);
    bus.decr_data_out = result_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg   <= '0;
      key_reg    <= '0;
      blk_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.ip_valid) begin
            data_reg <= bus.ip_data;
            key_reg  <= bus.ip_key;
          end
        end
        INIT: begin
          blk_reg <= data_reg ^ rk_sel;
          cnt_reg <= 4'd9;
        end
        ROUND: begin
          blk_reg <= round_out;
          cnt_reg <= cnt_reg - 4'd1;
        end
        FINAL:   result_reg <= ark_vec;
        default: ;
      endcase
    end
  end
endmodule
